// File: rtl/multi_debounce_pulser.sv
// N-channel push-button conditioner: 2-flop synchroniser, stability-count debouncer,
// one-cycle press/release pulses and an optional hold-to-auto-repeat pulse stream.
module multi_debounce_pulser #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 255,
    parameter int CNT_W         = 8,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int HOLD_W        = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] din_i,
    input  logic [N_CH-1:0] en_repeat_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_pulse_o,
    output logic [N_CH-1:0] fall_pulse_o,
    output logic [N_CH-1:0] repeat_pulse_o,
    output logic            any_event_o
);

    // Repeat phase per channel
    //   state    | meaning
    //   PH_FIRST | waiting HOLD_CYCLES for the first repeat after a press
    //   PH_NEXT  | repeating every REPEAT_CYCLES
    typedef enum logic {PH_FIRST = 1'b0, PH_NEXT = 1'b1} phase_e;

    localparam logic [CNT_W-1:0]  STABLE_LIM = CNT_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LIM   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LIM    = HOLD_W'(REPEAT_CYCLES - 1);

    logic [N_CH-1:0] s1_q, s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic              cand_q, cand_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              level_q, level_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;
        logic              rep_q, rep_d;
        logic [HOLD_W-1:0] hcnt_q, hcnt_d;
        phase_e            phase_q, phase_d;
        logic              accept;

        assign accept = (cnt_q == STABLE_LIM) && (cand_q != level_q);

        always_comb begin
            cand_d  = cand_q;
            cnt_d   = cnt_q;
            hcnt_d  = hcnt_q;
            phase_d = phase_q;
            rep_d   = 1'b0;

            if (s2_q[c] != cand_q) begin
                cand_d = s2_q[c];
                cnt_d  = '0;
            end else if (cnt_q != STABLE_LIM) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            level_d = accept ? cand_q : level_q;
            rise_d  = accept && cand_q;
            fall_d  = accept && !cand_q;

            // An accepted edge (rise or fall) always restarts the hold timer and
            // suppresses any repeat that would have fired on the same edge.
            if (accept || !level_q || !en_repeat_i[c]) begin
                hcnt_d  = '0;
                phase_d = PH_FIRST;
            end else if (hcnt_q == ((phase_q == PH_FIRST) ? HOLD_LIM : REP_LIM)) begin
                rep_d   = 1'b1;
                hcnt_d  = '0;
                phase_d = PH_NEXT;
            end else begin
                hcnt_d = hcnt_q + HOLD_W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cand_q  <= 1'b0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rep_q   <= 1'b0;
                hcnt_q  <= '0;
                phase_q <= PH_FIRST;
            end else begin
                cand_q  <= cand_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                rep_q   <= rep_d;
                hcnt_q  <= hcnt_d;
                phase_q <= phase_d;
            end
        end

        assign level_o[c]        = level_q;
        assign rise_pulse_o[c]   = rise_q;
        assign fall_pulse_o[c]   = fall_q;
        assign repeat_pulse_o[c] = rep_q;
    end

    assign any_event_o = |(rise_pulse_o | fall_pulse_o | repeat_pulse_o);

endmodule

// File: tb/tb_multi_debounce_pulser.sv
// Directed bench for multi_debounce_pulser with short timing parameters
// (STABLE=4, HOLD=10, REPEAT=3): acceptance lands 8 steps after din changes.
module tb_multi_debounce_pulser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] en_repeat;
    logic [3:0] level, rise, fall, rep;
    logic       any_event;

    int n_tests = 0;
    int n_fail  = 0;

    multi_debounce_pulser #(
        .N_CH(4), .STABLE_CYCLES(4), .CNT_W(3),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .HOLD_W(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din), .en_repeat_i(en_repeat),
        .level_o(level), .rise_pulse_o(rise), .fall_pulse_o(fall),
        .repeat_pulse_o(rep), .any_event_o(any_event)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; en_repeat = '0;
        #3;
        n_tests++;
        if ({level, rise, fall, rep, any_event} !== 17'b0) begin
            n_fail++; $display("FAIL reset_async: got %b expected 0", {level, rise, fall, rep, any_event});
        end
        step(); step();
        n_tests++;
        if ({level, rise, fall, rep, any_event} !== 17'b0) begin
            n_fail++; $display("FAIL reset_clocked: got %b expected 0", {level, rise, fall, rep, any_event});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_tests++;
            if ({level, rise, fall, rep, any_event} !== 17'b0) begin
                n_fail++; $display("FAIL reset_release k=%0d: got %b expected 0", k, {level, rise, fall, rep, any_event});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] e_lvl, e_rise, e_fall;
        din[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_rise = (k == 8)  ? 4'b0001 : 4'b0000;
            e_fall = (k == 18) ? 4'b0001 : 4'b0000;
            e_lvl  = (k >= 8 && k < 18) ? 4'b0001 : 4'b0000;
            n_tests++;
            if ({level, rise, fall, rep} !== {e_lvl, e_rise, e_fall, 4'b0000}) begin
                n_fail++; $display("FAIL clean_press k=%0d: got lvl %b r %b f %b rp %b expected lvl %b r %b f %b rp 0000",
                                   k, level, rise, fall, rep, e_lvl, e_rise, e_fall);
            end
            if (k == 10) din[0] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        int n_rise = 0, n_fall = 0, rise_k = -1;
        for (int b = 0; b < 4; b++) begin
            din[1] = (b % 2 == 0);
            step(); step();
            if (rise[1]) n_rise++;
            if (fall[1]) n_fall++;
        end
        din[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rise[1]) begin n_rise++; rise_k = k; end
            if (fall[1]) n_fall++;
        end
        n_tests++;
        if (n_rise !== 1 || rise_k !== 8) begin
            n_fail++; $display("FAIL bounce_rise: got %0d pulses at k=%0d expected 1 at k=8", n_rise, rise_k);
        end
        n_tests++;
        if (n_fall !== 0 || level[1] !== 1'b1) begin
            n_fail++; $display("FAIL bounce_fall: got %0d falls lvl %b expected 0 falls lvl 1", n_fall, level[1]);
        end
        din[1] = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        n_tests++;
        if (level !== 4'b0000) begin
            n_fail++; $display("FAIL bounce_release: got lvl %b expected 0000", level);
        end
    endtask

    task automatic test_repeat();
        logic e_rep, e_rise, e_fall;
        for (int pass = 0; pass < 2; pass++) begin
            en_repeat[2] = (pass == 0);
            din[2] = 1'b1;
            for (int k = 1; k <= 55; k++) begin
                step();
                e_rise = (k == 8);
                e_fall = (k == 46);
                e_rep  = (pass == 0) && (k >= 18) && (k <= 46) && ((k - 18) % 3 == 0);
                n_tests++;
                if ({rise[2], fall[2], rep[2]} !== {e_rise, e_fall, e_rep}) begin
                    n_fail++; $display("FAIL repeat en=%0d k=%0d: got r%b f%b rp%b expected r%b f%b rp%b",
                                       en_repeat[2], k, rise[2], fall[2], rep[2], e_rise, e_fall, e_rep);
                end
                if (k == 38) din[2] = 1'b0;
            end
        end
        en_repeat[2] = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] e_lvl, e_rise;
        din[0] = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        n_tests++;
        if (level !== 4'b0001) begin
            n_fail++; $display("FAIL areset_pre: got lvl %b expected 0001", level);
        end
        din[3] = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({level, rise, fall, rep, any_event} !== 17'b0) begin
            n_fail++; $display("FAIL areset_immediate: got %b expected 0", {level, rise, fall, rep, any_event});
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            e_rise = (k == 8) ? 4'b1001 : 4'b0000;
            e_lvl  = (k >= 8) ? 4'b1001 : 4'b0000;
            n_tests++;
            if ({level, rise, fall} !== {e_lvl, e_rise, 4'b0000}) begin
                n_fail++; $display("FAIL areset_after k=%0d: got lvl %b r %b f %b expected lvl %b r %b f 0000",
                                   k, level, rise, fall, e_lvl, e_rise);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e_lvl, e_fall;
        logic       e_any;
        din[0] = 1'b0; din[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            e_fall = (k == 8) ? 4'b1001 : 4'b0000;
            e_lvl  = (k >= 8) ? 4'b0000 : 4'b1001;
            e_any  = (k == 8);
            n_tests++;
            if ({level, fall, any_event} !== {e_lvl, e_fall, e_any}) begin
                n_fail++; $display("FAIL simultaneous k=%0d: got lvl %b f %b any %b expected lvl %b f %b any %b",
                                   k, level, fall, any_event, e_lvl, e_fall, e_any);
            end
        end
    endtask

    task automatic test_glitch();
        din[0] = 1'b1;
        step(); step(); step();
        din[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if ({level, rise, fall, rep, any_event} !== 17'b0) begin
                n_fail++; $display("FAIL glitch k=%0d: got %b expected 0", k, {level, rise, fall, rep, any_event});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_async_reset();
        test_simultaneous();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
